alu_core: RTL and testbench

Parameterised integer ALU with registered result and flags. Performs add, subtract-with-borrow, bitwise logic and four shift types on two WIDTH-bit operands. The datapath is combinational and all outputs are captured in one output register stage, so the block drops straight into a pipelined execute stage.

---
 rtl/alu_core_pkg.sv | 29 ++
 rtl/alu_comb.sv | 70 +++++++
 rtl/alu_core.sv | 65 ++++++
 tb/tb_alu_core.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_core_pkg.sv
// -----------------------------------------------------------------------------
// Module  : alu_ops (package)
// Purpose : Opcode encoding shared by the ALU datapath and its benches.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package alu_ops;

    typedef enum logic [3:0] {
        ADD_OP      = 4'd0,
        SUB_OP      = 4'd1,
        AND_OP      = 4'd2,
        OR_OP       = 4'd3,
        XOR_OP      = 4'd4,
        NOT_OP      = 4'd5,
        LL_SHIFT_OP = 4'd6,
        LR_SHIFT_OP = 4'd7,
        AL_SHIFT_OP = 4'd8,
        AR_SHIFT_OP = 4'd9
    } opcode_t;

    // Codes from RESERVED_MIN through RESERVED_MAX decode to a zero result.
    localparam logic [3:0] RESERVED_MIN = 4'd10;
    localparam logic [3:0] RESERVED_MAX = 4'd15;

endpackage

`default_nettype wire

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// Module  : alu_comb
// Purpose : Combinational ALU datapath and flag generation, WIDTH bits wide.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_comb
    import alu_ops::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam logic [WIDTH:0] C_WIDTH = WIDTH[WIDTH:0];

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_big_shift;
    logic [WIDTH-1:0] w_sign_fill;
    opcode_t          w_op;

    assign w_op        = opcode_t'(opcode);
    assign w_sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    // A negative WIDTH+1-bit difference means a borrow out of the top bit.
    assign w_diff      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    assign w_big_shift = ({1'b0, b} >= C_WIDTH);
    assign w_sign_fill = {WIDTH{a[WIDTH-1]}};

    always_comb begin
        y        = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (w_op)
            ADD_OP: begin
                y        = w_sum[WIDTH-1:0];
                cout     = w_sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            SUB_OP: begin
                y        = w_diff[WIDTH-1:0];
                cout     = w_diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            AND_OP: y = a & b;
            OR_OP:  y = a | b;
            XOR_OP: y = a ^ b;
            NOT_OP: y = ~a;
            LL_SHIFT_OP, AL_SHIFT_OP: y = w_big_shift ? '0 : (a << b);
            LR_SHIFT_OP:              y = w_big_shift ? '0 : (a >> b);
            AR_SHIFT_OP: y = w_big_shift ? w_sign_fill : WIDTH'($signed(a) >>> b);
            default: y = '0;
        endcase
    end

    assign negative = y[WIDTH-1];
    assign zero     = (y == '0);

endmodule

`default_nettype wire

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// Module  : alu_core
// Purpose : Integer ALU with a single registered output stage for result and flags.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_core
    import alu_ops::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    logic [WIDTH-1:0] w_y;
    logic             w_cout;
    logic             w_overflow;
    logic             w_negative;
    logic             w_zero;

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .opcode  (opcode),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .y       (w_y),
        .cout    (w_cout),
        .overflow(w_overflow),
        .negative(w_negative),
        .zero    (w_zero)
    );

    // zero is cleared in reset on purpose, even though y is also zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
        end else begin
            y        <= w_y;
            cout     <= w_cout;
            overflow <= w_overflow;
            negative <= w_negative;
            zero     <= w_zero;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// Module  : tb_alu_core
// Purpose : Scoreboard bench for alu_core with WIDTH=4 directed vectors.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_alu_core;
    import alu_ops::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        logic         v;
        logic         n;
        logic         z;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   opcode = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] y;
    logic         cout, overflow, negative, zero;
    logic         vld = 1'b0;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    alu_core #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .y       (y),
        .cout    (cout),
        .overflow(overflow),
        .negative(negative),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic r, input logic [3:0] op, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic ic, input logic [W-1:0] ey,
                         input logic ec, input logic ev, input logic en, input logic ez,
                         input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; opcode = op; a = ia; b = ib; cin = ic; vld = 1'b1;
        e.y = ey; e.c = ec; e.v = ev; e.n = en; e.z = ez; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per edge at which vld was high.
    initial begin
        logic s;
        exp_t e;
        forever begin
            @(posedge clk);
            s = vld;
            #1;
            if (s) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: no expected entry queued");
                end else begin
                    e = exp_q.pop_front();
                    if (y !== e.y || cout !== e.c || overflow !== e.v ||
                        negative !== e.n || zero !== e.z) begin
                        errors++;
                        $display("FAIL %s: got y=%b c=%b v=%b n=%b z=%b, required y=%b c=%b v=%b n=%b z=%b",
                                 e.name, y, cout, overflow, negative, zero,
                                 e.y, e.c, e.v, e.n, e.z);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges with arbitrary inputs.
        issue(1, ADD_OP, 4'b1111, 4'b0001, 1, 4'b0000, 0, 0, 0, 0, "reset_0");
        issue(1, SUB_OP, 4'b0000, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, "reset_1");

        issue(0, ADD_OP, 4'b1000, 4'b0111, 1, 4'b0000, 1, 0, 0, 1, "add_carry_zero");
        issue(0, ADD_OP, 4'b0100, 4'b0110, 1, 4'b1011, 0, 1, 1, 0, "add_overflow");
        issue(0, SUB_OP, 4'b1000, 4'b0011, 1, 4'b0100, 0, 1, 0, 0, "sub_8_3_1");
        issue(0, SUB_OP, 4'b1111, 4'b1000, 1, 4'b0110, 0, 0, 0, 0, "sub_15_8_1");
        issue(0, SUB_OP, 4'b0000, 4'b0001, 0, 4'b1111, 1, 0, 1, 0, "sub_borrow");
        issue(0, AND_OP, 4'b1010, 4'b0111, 1, 4'b0010, 0, 0, 0, 0, "and");
        issue(0, OR_OP,  4'b1000, 4'b0100, 1, 4'b1100, 0, 0, 1, 0, "or");
        issue(0, XOR_OP, 4'b1100, 4'b1010, 1, 4'b0110, 0, 0, 0, 0, "xor");
        issue(0, NOT_OP, 4'b1000, 4'b1111, 1, 4'b0111, 0, 0, 0, 0, "not");
        issue(0, LL_SHIFT_OP, 4'b0101, 4'b0001, 1, 4'b1010, 0, 0, 1, 0, "ll_1");
        issue(0, LL_SHIFT_OP, 4'b1000, 4'b0001, 1, 4'b0000, 0, 0, 0, 1, "ll_out");
        issue(0, LR_SHIFT_OP, 4'b1011, 4'b0001, 1, 4'b0101, 0, 0, 0, 0, "lr_1");
        issue(0, AR_SHIFT_OP, 4'b1001, 4'b0001, 1, 4'b1100, 0, 0, 1, 0, "ar_1001");
        issue(0, AR_SHIFT_OP, 4'b1110, 4'b0001, 1, 4'b1111, 0, 0, 1, 0, "ar_1110");
        issue(0, AR_SHIFT_OP, 4'b0011, 4'b0001, 1, 4'b0001, 0, 0, 0, 0, "ar_0011");
        issue(0, LL_SHIFT_OP, 4'b0001, 4'b0100, 1, 4'b0000, 0, 0, 0, 1, "ll_big");
        issue(0, AR_SHIFT_OP, 4'b1000, 4'b0101, 1, 4'b1111, 0, 0, 1, 0, "ar_big");
        issue(0, AL_SHIFT_OP, 4'b0011, 4'b0010, 1, 4'b1100, 0, 0, 1, 0, "al_2");
        issue(0, LR_SHIFT_OP, 4'b1000, 4'b0100, 1, 4'b0000, 0, 0, 0, 1, "lr_big");
        issue(0, AR_SHIFT_OP, 4'b0110, 4'b0111, 1, 4'b0000, 0, 0, 0, 1, "ar_big_pos");
        issue(0, LR_SHIFT_OP, 4'b1011, 4'b0000, 1, 4'b1011, 0, 0, 1, 0, "lr_zero_amt");
        issue(0, 4'd12,  4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 1, "reserved_12");
        issue(0, 4'd15,  4'b0101, 4'b0011, 0, 4'b0000, 0, 0, 0, 1, "reserved_15");

        // Back-to-back stream with reset pulsed on the third operation.
        issue(0, ADD_OP, 4'b0011, 4'b0001, 0, 4'b0100, 0, 0, 0, 0, "pipe_op1");
        issue(0, XOR_OP, 4'b1111, 4'b0101, 0, 4'b1010, 0, 0, 1, 0, "pipe_op2");
        issue(1, OR_OP,  4'b1100, 4'b0011, 0, 4'b0000, 0, 0, 0, 0, "pipe_op3_rst");
        issue(0, AR_SHIFT_OP, 4'b1000, 4'b0010, 0, 4'b1110, 0, 0, 1, 0, "pipe_op4");

        @(negedge clk);
        vld = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
